// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker: sweeps all 16 2-bit operand pairs through an external comparator and checks R/G/B; optional stop-on-first-fail via CMP_CHK_STOPFAIL_EN
module cmp_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_1,
  output logic       a_0,
  output logic       b_1,
  output logic       b_0,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_idx
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
`ifdef CMP_CHK_STOPFAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;
  state_t state;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic [2:0] expected;
  logic mismatch, last;
  // golden response for the vector currently on the operands and end-of-sweep decision
  always_comb begin
    expected = {idx[3:2] > idx[1:0], idx[3:2] == idx[1:0], idx[3:2] < idx[1:0]};
    mismatch = {R, G, B} != expected;
    last     = (idx == 4'd15) || (STOP && mismatch);
  end
  assign pass = done && (err_cnt == 5'd0);
  // sweep sequencer with registered operands and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      cnt              <= '0;
      {a_1, a_0, b_1, b_0} <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_cnt          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      case (state)
        IDLE, FIN: if (start) begin
          state            <= DRIVE;
          idx              <= '0;
          err_cnt          <= '0;
          first_fail_valid <= 1'b0;
          first_fail_idx   <= '0;
          busy             <= 1'b1;
          done             <= 1'b0;
        end
        DRIVE: begin
          {a_1, a_0, b_1, b_0} <= idx;
          if (SETTLE_CYCLES == 0) state <= CHECK;
          else begin
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
        end
        SETTLE: if (cnt == '0) state <= CHECK; else cnt <= cnt - 1'b1;
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt == 5'd16 ? err_cnt : err_cnt + 5'd1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
          end
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            {a_1, a_0, b_1, b_0} <= '0;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sweep_checker.sv
// tb_cmp_sweep_checker: checks the sweep checker against comparator models with injected faults
module tb_cmp_sweep_checker;
`ifdef CMP_CHK_STOPFAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic a_1, a_0, b_1, b_0, R, G, B, busy, done, pass, ffv;
  logic [4:0] err_cnt;
  logic [3:0] ffi;
  logic c_1, c_0, d_1, d_0, R2, G2, B2, busy2, done2, pass2, ffv2;
  logic [4:0] err_cnt2;
  logic [3:0] ffi2;
  int tests = 0, fails = 0;
  int mode = 0;
  logic [2:0] flip [16];
  always #5 clk = ~clk;

  cmp_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_1(a_1), .a_0(a_0), .b_1(b_1), .b_0(b_0),
    .R(R), .G(G), .B(B),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_valid(ffv), .first_fail_idx(ffi));

  cmp_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a_1(c_1), .a_0(c_0), .b_1(d_1), .b_0(d_0),
    .R(R2), .G(G2), .B(B2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_fail_valid(ffv2), .first_fail_idx(ffi2));

  always_comb begin
    logic [1:0] a, b;
    logic [2:0] ideal;
    a = {a_1, a_0};
    b = {b_1, b_0};
    ideal = {a > b, a == b, a < b};
    {R, G, B} = ideal;
    if (mode == 1) {R, G, B} = ideal & 3'b101;
    if (mode == 2) {R, G, B} = {ideal[0], ideal[1], ideal[2]};
    if (mode == 3) {R, G, B} = ideal ^ flip[{a, b}];
  end

  always_comb begin
    logic [1:0] a, b;
    a = {c_1, c_0};
    b = {d_1, d_0};
    {R2, G2, B2} = {a > b, a == b, a < b};
  end

  `define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp); end end

  function automatic bit bad(input int m, input int v);
    int a = v / 4, b = v % 4;
    case (m)
      1: return a == b;
      2: return a != b;
      3: return flip[v] != 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic sweep(input int m, input bit hold);
    int nerr = 0, first = 0, last_v, dcyc, enerr;
    mode = m;
    for (int v = 15; v >= 0; v--) if (bad(m, v)) begin nerr++; first = v; end
    if (STOP && nerr > 0) begin last_v = first; dcyc = 4 * (first + 1); enerr = 1; end
    else begin last_v = 15; dcyc = 64; enerr = nerr; end
    @(negedge clk) start = 1;
    @(negedge clk) if (!hold) start = 0;
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      if ((c - 1) % 4 == 0 && (c - 1) / 4 <= last_v)
        `CHK("operands", {a_1, a_0, b_1, b_0}, 4'((c - 1) / 4))
      if (c == 1) `CHK("busy_start", busy, 1'b1)
      if (c == dcyc - 1) `CHK("done_early", done, 1'b0)
    end
    `CHK("done", done, 1'b1)
    `CHK("busy_end", busy, 1'b0)
    `CHK("operands_done", {a_1, a_0, b_1, b_0}, 4'd0)
    `CHK("err_cnt", err_cnt, 5'(enerr))
    `CHK("ff_valid", ffv, 1'(nerr > 0))
    `CHK("ff_idx", ffi, 4'(nerr > 0 ? first : 0))
    `CHK("pass", pass, 1'(nerr == 0))
  endtask

  initial begin
    repeat (2) @(negedge clk);
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_err", err_cnt, 5'd0)
    `CHK("rst_opnd", {a_1, a_0, b_1, b_0}, 4'd0)
    `CHK("rst_ffv", ffv, 1'b0)
    rst_n = 1;
    @(negedge clk);
    `CHK("idle_pass", pass, 1'b0)
    sweep(0, 0);
    sweep(1, 0);
    sweep(2, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) flip[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      sweep(3, 0);
    end
    mode = 1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (19) @(negedge clk);
    `CHK("mid_err", err_cnt, 5'd1)
    #2 rst_n = 0;
    #1;
    `CHK("arst_busy", busy, 1'b0)
    `CHK("arst_err", err_cnt, 5'd0)
    `CHK("arst_ffv", ffv, 1'b0)
    `CHK("arst_opnd", {a_1, a_0, b_1, b_0}, 4'd0)
    @(negedge clk) rst_n = 1;
    sweep(0, 0);
    sweep(1, 1);
    @(negedge clk);
    `CHK("restart_done", done, 1'b0)
    `CHK("restart_busy", busy, 1'b1)
    `CHK("restart_err", err_cnt, 5'd0)
    `CHK("restart_ffv", ffv, 1'b0)
    start = 0;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    `CHK("restart_fin", done, 1'b1)
    `CHK("restart_err_fin", err_cnt, 5'(STOP ? 1 : 4))
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c % 2 == 1) `CHK("s0_operands", {c_1, c_0, d_1, d_0}, 4'((c - 1) / 2))
      if (c == 31) `CHK("s0_done_early", done2, 1'b0)
    end
    `CHK("s0_done", done2, 1'b1)
    `CHK("s0_pass", pass2, 1'b1)
    `CHK("s0_err", err_cnt2, 5'd0)
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
